slave_bb_q: RTL and testbench

- Parametrised successor to the slave bus bridge. Sits between the local bus master and the remote group's bus.
- Accepts selected read/write requests into a request FIFO and forwards them one at a time with a valid/ready handshake.
- For reads, waits for the remote response and returns it, with a timeout and an error flag that the old bridge did not have.

---
 rtl/slave_bb_q_pkg.sv | 14 +
 rtl/slave_bb_q_if.sv | 35 +++
 rtl/slave_bb_q_fifo.sv | 55 +++++
 rtl/slave_bb_q.sv | 107 ++++++++++
 tb/tb_slave_bb_q.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/slave_bb_q_pkg.sv
// Shared types for the slave bus bridge: FSM states, mode encoding, request packing.
// Request entries are packed as {mode, addr, data} with mode in the MSB.
package slave_bb_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  localparam logic MODE_WR = 1'b1;
  localparam logic MODE_RD = 1'b0;

  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/slave_bb_q_if.sv
// Local master request port, remote forward port and read completion port of the bridge.
// The slave modport is the bridge side; the master modport is the driving environment.
interface slave_bb_q_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LVL_W  = 3
);
  logic              sl;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              mode_in;
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] address_out;
  logic [DATA_W-1:0] data_out;
  logic              mode_out;
  logic              valid_out;
  logic              remote_ready;
  logic              sl_valid;
  logic [DATA_W-1:0] sl_rdata;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              rd_err;
  logic [LVL_W-1:0]  level;

  modport slave (
    input  sl, address, wdata, mode_in, valid, remote_ready, sl_valid, sl_rdata,
    output ready, address_out, data_out, mode_out, valid_out, data_in, valid_in, rd_err, level
  );

  modport master (
    output sl, address, wdata, mode_in, valid, remote_ready, sl_valid, sl_rdata,
    input  ready, address_out, data_out, mode_out, valid_out, data_in, valid_in, rd_err, level
  );
endinterface

// File: rtl/slave_bb_q_fifo.sv
// Synchronous request FIFO with registered occupancy; head is visible combinationally.
// Zero-latency head read; push is ignored when full and pop is ignored when empty.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/slave_bb_q.sv
// Slave bus bridge: queues selected requests, forwards them one at a time, returns read data or timeout.
// Push-to-valid_out two edges, response to valid_in one edge; ready drops only when the queue is full.
module slave_bb_q
  import slave_bb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  slave_bb_q_if.slave  bus
);

  localparam int REQ_W = req_w(ADDR_W, DATA_W);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  state_t            r_state;
  state_t            w_next;
  logic [TMR_W-1:0]  r_timer;
  logic [DATA_W-1:0] r_data_in;
  logic              r_valid_in;
  logic              r_rd_err;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_send;
  logic              w_timeout;
  logic              w_complete;
  logic [REQ_W-1:0]  w_head;
  logic [LVL_W-1:0]  w_level;

  assign w_push     = bus.sl && bus.valid && !w_full;
  assign w_send     = (r_state == SEND);
  assign w_timeout  = (TIMEOUT != 0) && (r_timer == TMR_LAST);
  assign w_complete = (r_state == WAIT) && (bus.sl_valid || w_timeout);

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({bus.mode_in, bus.address, bus.wdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) w_next = SEND;
      SEND: begin
        if (bus.remote_ready) begin
          w_pop  = 1'b1;
          w_next = (w_head[REQ_W-1] == MODE_WR) ? IDLE : WAIT;
        end
      end
      WAIT:    if (bus.sl_valid || w_timeout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Cleared while the read is being handed off, so WAIT always starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     r_timer <= '0;
    else if (r_state == SEND)                    r_timer <= '0;
    else if (r_state == WAIT && r_timer != '1)   r_timer <= r_timer + TMR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_in <= 1'b0;
      r_rd_err   <= 1'b0;
      r_data_in  <= '0;
    end else if (w_complete) begin
      r_valid_in <= 1'b1;
      r_rd_err   <= !bus.sl_valid;
      r_data_in  <= bus.sl_valid ? bus.sl_rdata : '0;
    end else begin
      r_valid_in <= 1'b0;
      r_rd_err   <= 1'b0;
    end
  end

  assign bus.ready       = !w_full;
  assign bus.level       = w_level;
  assign bus.valid_out   = w_send;
  assign bus.mode_out    = w_send & w_head[REQ_W-1];
  assign bus.address_out = w_send ? w_head[REQ_W-2 -: ADDR_W] : '0;
  assign bus.data_out    = w_send ? w_head[DATA_W-1:0] : '0;
  assign bus.data_in     = r_data_in;
  assign bus.valid_in    = r_valid_in;
  assign bus.rd_err      = r_rd_err;

endmodule

// File: tb/tb_slave_bb_q.sv
// Directed self-checking bench for slave_bb_q with DEPTH=4 and TIMEOUT=8.
module tb_slave_bb_q;
  import slave_bb_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  slave_bb_q_if #(.ADDR_W(16), .DATA_W(8), .LVL_W(3)) bus ();

  slave_bb_q #(.ADDR_W(16), .DATA_W(8), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic mode, input logic [15:0] addr, input logic [7:0] data);
    bus.mode_in = mode;
    bus.address = addr;
    bus.wdata   = data;
    bus.valid   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.sl = 1'b0; bus.address = '0; bus.wdata = '0; bus.mode_in = 1'b0; bus.valid = 1'b0;
    bus.remote_ready = 1'b1; bus.sl_valid = 1'b0; bus.sl_rdata = '0;
    #1;
    chk("rst_ready",     32'(bus.ready),     32'd1);
    chk("rst_level",     32'(bus.level),     32'd0);
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_valid_in",  32'(bus.valid_in),  32'd0);
    chk("rst_rd_err",    32'(bus.rd_err),    32'd0);
    chk("rst_data_in",   32'(bus.data_in),   32'd0);
    tick(); tick();
    rst = 1'b0;

    // Posted write
    bus.sl = 1'b1;
    drive_req(MODE_WR, 16'h1234, 8'hAB);
    tick();
    bus.valid = 1'b0;
    chk("wr_level_push",   32'(bus.level),     32'd1);
    chk("wr_vout_early",   32'(bus.valid_out), 32'd0);
    tick();
    chk("wr_vout",         32'(bus.valid_out),   32'd1);
    chk("wr_addr",         32'(bus.address_out), 32'h1234);
    chk("wr_data",         32'(bus.data_out),    32'hAB);
    chk("wr_mode",         32'(bus.mode_out),    32'd1);
    tick();
    chk("wr_vout_done",    32'(bus.valid_out), 32'd0);
    chk("wr_level_done",   32'(bus.level),     32'd0);
    chk("wr_no_valid_in",  32'(bus.valid_in),  32'd0);

    // Read with response three edges after acceptance
    drive_req(MODE_RD, 16'h5678, 8'h00);
    tick();
    bus.valid = 1'b0;
    tick();
    chk("rd_vout", 32'(bus.valid_out),   32'd1);
    chk("rd_addr", 32'(bus.address_out), 32'h5678);
    chk("rd_mode", 32'(bus.mode_out),    32'd0);
    tick();
    tick(); tick();
    chk("rd_no_early_vin", 32'(bus.valid_in), 32'd0);
    bus.sl_valid = 1'b1; bus.sl_rdata = 8'hCD;
    tick();
    bus.sl_valid = 1'b0; bus.sl_rdata = 8'h00;
    chk("rd_valid_in", 32'(bus.valid_in), 32'd1);
    chk("rd_data_in",  32'(bus.data_in),  32'hCD);
    chk("rd_err0",     32'(bus.rd_err),   32'd0);
    tick();
    chk("rd_pulse_one", 32'(bus.valid_in), 32'd0);
    chk("rd_data_hold", 32'(bus.data_in),  32'hCD);

    // Timeout on a read, then the queued write issues
    drive_req(MODE_RD, 16'h0BAD, 8'h00);
    tick();
    drive_req(MODE_WR, 16'h0042, 8'h55);
    tick();
    bus.valid = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("to_not_yet", 32'(bus.valid_in), 32'd0);
    tick();
    chk("to_valid_in", 32'(bus.valid_in), 32'd1);
    chk("to_rd_err",   32'(bus.rd_err),   32'd1);
    chk("to_data_in",  32'(bus.data_in),  32'd0);
    tick();
    chk("to_vin_clear", 32'(bus.valid_in),    32'd0);
    chk("to_err_clear", 32'(bus.rd_err),      32'd0);
    chk("to_next_vout", 32'(bus.valid_out),   32'd1);
    chk("to_next_addr", 32'(bus.address_out), 32'h0042);
    chk("to_next_data", 32'(bus.data_out),    32'h55);
    tick();
    tick();

    // Stray response while idle
    bus.sl_valid = 1'b1; bus.sl_rdata = 8'hEE;
    tick();
    bus.sl_valid = 1'b0;
    tick();
    chk("stray_vin",  32'(bus.valid_in), 32'd0);
    chk("stray_data", 32'(bus.data_in),  32'd0);

    // Fill with remote stalled, fifth request refused
    bus.remote_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive_req(MODE_WR, 16'(i), 8'(8'h10 + i));
      tick();
      if (i == 4) begin
        chk("full_level", 32'(bus.level), 32'd4);
        chk("full_ready", 32'(bus.ready), 32'd0);
      end
    end
    bus.valid = 1'b0;
    chk("full_refused", 32'(bus.level),       32'd4);
    chk("full_head",    32'(bus.address_out), 32'h0001);
    bus.remote_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_vout", 32'(bus.valid_out),   32'd1);
      chk("drain_addr", 32'(bus.address_out), 32'(k));
      tick();
      chk("drain_bubble", 32'(bus.valid_out), 32'd0);
      tick();
    end
    chk("drain_level", 32'(bus.level), 32'd0);
    chk("drain_ready", 32'(bus.ready), 32'd1);

    // Select gating
    bus.sl = 1'b0;
    drive_req(MODE_WR, 16'h0BEE, 8'h01);
    tick(); tick();
    chk("nosel_level", 32'(bus.level),     32'd0);
    chk("nosel_vout",  32'(bus.valid_out), 32'd0);
    bus.sl = 1'b1;
    drive_req(MODE_RD, 16'h0077, 8'h00);
    tick();
    bus.valid = 1'b0;
    bus.sl = 1'b0;
    tick(); tick(); tick();
    bus.sl_valid = 1'b1; bus.sl_rdata = 8'hCD;
    tick();
    bus.sl_valid = 1'b0;
    chk("nosel_rd_vin",  32'(bus.valid_in), 32'd1);
    chk("nosel_rd_data", 32'(bus.data_in),  32'hCD);
    chk("nosel_rd_err",  32'(bus.rd_err),   32'd0);
    tick();

    // Asynchronous reset while a request is being presented
    bus.sl = 1'b1;
    bus.remote_ready = 1'b0;
    drive_req(MODE_WR, 16'h0321, 8'h09);
    tick();
    bus.valid = 1'b0;
    tick();
    chk("arst_pre_vout", 32'(bus.valid_out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vout", 32'(bus.valid_out), 32'd0);
    tick();
    rst = 1'b0;
    bus.remote_ready = 1'b1;

    // Asynchronous reset during WAIT with another entry queued
    drive_req(MODE_RD, 16'h0099, 8'h00);
    tick();
    drive_req(MODE_WR, 16'h0100, 8'h02);
    tick();
    bus.valid = 1'b0;
    tick();
    tick();
    chk("wrst_pre_level", 32'(bus.level), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("wrst_level",   32'(bus.level),     32'd0);
    chk("wrst_vout",    32'(bus.valid_out), 32'd0);
    chk("wrst_vin",     32'(bus.valid_in),  32'd0);
    chk("wrst_data_in", 32'(bus.data_in),   32'd0);
    tick();
    rst = 1'b0;
    bus.sl_valid = 1'b1; bus.sl_rdata = 8'hEE;
    tick();
    bus.sl_valid = 1'b0;
    tick();
    chk("wrst_late_vin",  32'(bus.valid_in), 32'd0);
    chk("wrst_late_data", 32'(bus.data_in),  32'd0);
    chk("wrst_ready",     32'(bus.ready),    32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
